load_store_unit: RTL and testbench

Sits between the EX-stage ALU result and dataMemory. It converts byte addresses into word indices for dataMemory. It performs byte and halfword lane selection with sign or zero extension on loads. dataMemory only writes whole words, so sub-word stores are done as a two-cycle read-modify-write, and the core is stalled for one cycle while that happens.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_ext.sv | 44 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memOp encodings, FSM states,
// access sizes and lane constants.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    SW  = 3'd5,
    SB  = 3'd6,
    SH  = 3'd7
  } mem_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_2 = 2'd2;

  function automatic acc_size_e op_size(input mem_op_e op);
    case (op)
      LW, SW:       op_size = SZ_WORD;
      LH, LHU, SH:  op_size = SZ_HALF;
      LB, LBU, SB:  op_size = SZ_BYTE;
      default:      op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// Combinational lane logic: extracts and extends a load lane, and builds the
// read-modify-write word by inserting store data into the selected lane.
module lsu_lane_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  acc_size_e   size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] ins_data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Little-endian lane extract with extension, and lane insert for merges
  always_comb begin
    byte_s  = word_i[{lane_i, 3'b000} +: 8];
    half_s  = word_i[{lane_i[1], 4'b0000} +: 16];
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = sign_ext_i ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
        merge_o[{lane_i, 3'b000} +: 8] = ins_data_i[7:0];
      end
      SZ_HALF: begin
        load_o = sign_ext_i ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
        merge_o[{lane_i[1], 4'b0000} +: 16] = ins_data_i[15:0];
      end
      SZ_WORD: begin
        load_o  = word_i;
        merge_o = ins_data_i;
      end
      default: begin
        load_o  = word_i;
        merge_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the ALU and a word-only dataMemory; sub-word stores
// are a one-stall read-modify-write. Build option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DM_DEPTH   = 64
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            memOp,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  misaligned,
  output logic [31:0]           dm_address,
  output logic [DATA_WIDTH-1:0] dm_writeData,
  output logic                  dm_memWrite,
  output logic                  dm_memRead,
  input  logic [DATA_WIDTH-1:0] dm_readData
);

  localparam int IDX_W = $clog2(DM_DEPTH);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [1:0]            lane_q, lane_d;

  mem_op_e   op_s;
  acc_size_e size_s;
  logic      sign_ext_s;
  logic      fault_s;
  logic      trap_s;
  logic [1:0] raw_lane_s;
  logic [1:0] eff_lane_s;
  logic [1:0] ext_lane_s;
  logic [31:0] load_s;
  logic [31:0] merged_s;
  logic        unused_s;

  assign op_s       = mem_op_e'(memOp);
  assign size_s     = op_size(op_s);
  assign sign_ext_s = !((op_s == LBU) || (op_s == LHU));
  assign raw_lane_s = address[1:0];
  assign fault_s    = ((size_s == SZ_WORD) && (raw_lane_s != 2'b00)) ||
                      ((size_s == SZ_HALF) && raw_lane_s[0]);

  assign dm_address = {{(32-IDX_W){1'b0}}, address[IDX_W+1:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s     = fault_s;
  assign eff_lane_s = raw_lane_s;
  assign unused_s   = ^{address[ADDR_WIDTH-1:IDX_W+2]};
`else
  assign trap_s   = 1'b0;
  assign unused_s = ^{address[ADDR_WIDTH-1:IDX_W+2], fault_s};

  // Force the low address bits to the natural alignment of the access
  always_comb begin
    case (size_s)
      SZ_WORD: eff_lane_s = LANE_0;
      SZ_HALF: eff_lane_s = raw_lane_s[1] ? LANE_2 : LANE_0;
      SZ_BYTE: eff_lane_s = raw_lane_s;
      default: eff_lane_s = raw_lane_s;
    endcase
  end
`endif

  // The lane unit is shared: MERGE replays the captured lane
  assign ext_lane_s = (state_q == MERGE) ? lane_q : eff_lane_s;

  lsu_lane_ext u_lane_ext (
    .word_i     (dm_readData),
    .lane_i     (ext_lane_s),
    .size_i     (size_s),
    .sign_ext_i (sign_ext_s),
    .ins_data_i (writeData),
    .load_o     (load_s),
    .merge_o    (merged_s)
  );

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    lane_d       = lane_q;
    readData     = '0;
    stall        = 1'b0;
    misaligned   = 1'b0;
    dm_memWrite  = 1'b0;
    dm_memRead   = 1'b0;
    dm_writeData = writeData;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (memWrite) begin
            misaligned = trap_s;
            if (trap_s) begin
              state_d = IDLE;
            end else if (size_s == SZ_WORD) begin
              dm_memWrite = 1'b1;
            end else begin
              stall       = 1'b1;
              dm_memRead  = 1'b1;
              merge_d     = merged_s;
              lane_d      = eff_lane_s;
              state_d     = MERGE;
            end
          end else if (memRead) begin
            misaligned = trap_s;
            dm_memRead = 1'b1;
            readData   = trap_s ? '0 : load_s;
          end else begin
            state_d = IDLE;
          end
        end
        MERGE: begin
          dm_writeData = merge_q;
          dm_memWrite  = 1'b1;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, merge word and lane registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against a byte-array reference model of dataMemory.
module tb_load_store_unit;

  localparam int DEPTH = 64;
  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset, memRead, memWrite;
  logic [2:0]  memOp;
  logic [31:0] address, writeData, readData, dm_address, dm_writeData, dm_readData;
  logic        stall, misaligned, dm_memWrite, dm_memRead;

  logic [31:0] dmem [DEPTH];
  logic [7:0]  ref_b [DEPTH*4];
  int total = 0;
  int bad = 0;
  int stall_cycles = 0;

  load_store_unit dut (
    .Clk(Clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memOp(memOp), .address(address), .writeData(writeData),
    .readData(readData), .stall(stall), .misaligned(misaligned),
    .dm_address(dm_address), .dm_writeData(dm_writeData),
    .dm_memWrite(dm_memWrite), .dm_memRead(dm_memRead),
    .dm_readData(dm_readData)
  );

  always #5 Clk = ~Clk;

  // dataMemory: asynchronous read, commit on the falling edge
  assign dm_readData = dmem[dm_address[5:0]];
  always @(negedge Clk) begin
    if (dm_memWrite === 1'b1) dmem[dm_address[5:0]] <= dm_writeData;
    if (stall === 1'b1) stall_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    else if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    else return 1;
  endfunction

  function automatic bit is_fault(input logic [2:0] op, input logic [31:0] a);
    return (a % nbytes(op)) != 0;
  endfunction

  // Byte index in the reference array actually touched by an access
  function automatic int eff_byte(input logic [2:0] op, input logic [31:0] a);
    int b;
    b = int'(a % (DEPTH*4));
    return b - (b % nbytes(op));
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[4*idx + k];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    longint v;
    int n, e;
    n = nbytes(op);
    e = eff_byte(op, a);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_b[e + k]) << (8*k));
    if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8*n - 1)))
      v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int e;
    e = eff_byte(op, a);
    for (int k = 0; k < nbytes(op); k++) ref_b[e + k] = 8'((d >> (8*k)) & 32'hFF);
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    dmem[idx] = w;
    for (int k = 0; k < 4; k++) ref_b[4*idx + k] = w[8*k +: 8];
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_idle();
    step();
    memRead = 1'b0; memWrite = 1'b0;
    #1;
    chk("idle_readData", readData, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a);
    step();
    memRead = 1'b1; memWrite = 1'b0; memOp = op; address = a;
    #1;
    chk("ld_stall", {31'd0, stall}, 32'd0);
    chk("ld_dm_address", dm_address, (a >> 2) % DEPTH);
    if (TRAP && is_fault(op, a)) begin
      chk("ld_trap_readData", readData, 32'd0);
      chk("ld_misaligned", {31'd0, misaligned}, 32'd1);
    end else begin
      chk("ld_readData", readData, ref_load(op, a));
      chk("ld_misaligned", {31'd0, misaligned}, 32'd0);
    end
  endtask

  task automatic do_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic rd_too);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    step();
    memRead = rd_too; memWrite = 1'b1; memOp = op; address = a; writeData = d;
    #1;
    chk("st_readData", readData, 32'd0);
    chk("st_dm_address", dm_address, 32'(idx));
    if (TRAP && is_fault(op, a)) begin
      chk("st_trap_misaligned", {31'd0, misaligned}, 32'd1);
      chk("st_trap_memWrite", {31'd0, dm_memWrite}, 32'd0);
      chk("st_trap_stall", {31'd0, stall}, 32'd0);
    end else if (op == OP_SW) begin
      ref_store(op, a, d);
      chk("sw_stall", {31'd0, stall}, 32'd0);
      chk("sw_memWrite", {31'd0, dm_memWrite}, 32'd1);
      chk("sw_writeData", dm_writeData, ref_word(idx));
    end else begin
      ref_store(op, a, d);
      chk("rmw0_stall", {31'd0, stall}, 32'd1);
      chk("rmw0_memWrite", {31'd0, dm_memWrite}, 32'd0);
      step();
      chk("rmw1_stall", {31'd0, stall}, 32'd0);
      chk("rmw1_memWrite", {31'd0, dm_memWrite}, 32'd1);
      chk("rmw1_writeData", dm_writeData, ref_word(idx));
    end
  endtask

  initial begin
    int s0;
    logic [2:0] op;
    logic [31:0] a;
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; memOp = OP_LW;
    address = 32'd0; writeData = 32'd0;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_memWrite", {31'd0, dm_memWrite}, 32'd0);
    chk("rst_memRead", {31'd0, dm_memRead}, 32'd0);
    chk("rst_readData", readData, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    step();
    reset = 1'b0; memRead = 1'b0;

    // Lane selection and extension
    preload(4, 32'h8899AABB);
    do_load(OP_LB, 32'h13);  chk("tp_lb", readData, 32'hFFFFFF88);
    do_load(OP_LBU, 32'h13); chk("tp_lbu", readData, 32'h00000088);
    do_load(OP_LH, 32'h10);  chk("tp_lh", readData, 32'hFFFFAABB);

    // Word store then read-back
    do_store(OP_SW, 32'h08, 32'hDEADBEEF, 1'b0);
    do_load(OP_LW, 32'h08); chk("tp_sw_lw", readData, 32'hDEADBEEF);

    // Byte RMW
    preload(2, 32'h11223344);
    do_store(OP_SB, 32'h09, 32'hABCDEF55, 1'b0);
    chk("tp_sb_merge", dm_writeData, 32'h11225544);
    do_load(OP_LW, 32'h08); chk("tp_sb_lw", readData, 32'h11225544);

    // Back-to-back RMWs
    preload(3, 32'h5A6B7C8D);
    s0 = stall_cycles;
    do_store(OP_SH, 32'h0E, 32'h1234CAFE, 1'b0);
    do_store(OP_SB, 32'h0C, 32'h00000001, 1'b0);
    do_idle();
    chk("tp_b2b_stalls", 32'(stall_cycles - s0), 32'd2);
    chk("tp_b2b_word3", dmem[3], 32'hCAFE7C01);

    // Reset during RMW cycle 0
    preload(5, 32'h01234567);
    step();
    memRead = 1'b0; memWrite = 1'b1; memOp = OP_SB; address = 32'h15; writeData = 32'hEE;
    #1; chk("rc0_stall_pre", {31'd0, stall}, 32'd1);
    #1; reset = 1'b1;
    #1; chk("rc0_stall", {31'd0, stall}, 32'd0);
    chk("rc0_memWrite", {31'd0, dm_memWrite}, 32'd0);
    chk("rc0_memRead", {31'd0, dm_memRead}, 32'd0);
    step();
    reset = 1'b0; memWrite = 1'b0;
    #1; chk("rc0_after_stall", {31'd0, stall}, 32'd0);
    do_load(OP_LW, 32'h14); chk("rc0_word", readData, 32'h01234567);

    // Reset during the MERGE cycle
    step();
    memRead = 1'b0; memWrite = 1'b1; memOp = OP_SH; address = 32'h16; writeData = 32'hBEEF;
    step();
    reset = 1'b1;
    #1; chk("rm_memWrite", {31'd0, dm_memWrite}, 32'd0);
    chk("rm_stall", {31'd0, stall}, 32'd0);
    step();
    reset = 1'b0; memWrite = 1'b0;
    do_load(OP_LW, 32'h14); chk("rm_word", readData, 32'h01234567);

    // Misaligned word store
    preload(1, 32'hA5A5A5A5);
    do_store(OP_SW, 32'h06, 32'h13572468, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    do_idle();
    chk("mis_word1", dmem[1], 32'hA5A5A5A5);
`else
    chk("mis_flag", {31'd0, misaligned}, 32'd0);
    do_idle();
    chk("mis_word1", dmem[1], 32'h13572468);
`endif

    // Random traffic, full 32-bit addresses exercise the index wrap
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) do_idle();
      else if (op >= OP_SW) do_store(op, a, $urandom, 1'($urandom_range(0, 1)));
      else do_load(op, a);
    end
    do_idle();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", dmem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
